// File: rtl/softmax_pkg.sv
// Shared softmax definitions: FSM encoding, derived widths, exponent LUT generator.
// Width helpers keep the top and the bench consistent for any parameter set.
package softmax_pkg;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EXP  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  function automatic int sum_bits(int exp_bits, int len);
    return exp_bits + $clog2(len);
  endfunction

  function automatic int d_bits(int bit_rep);
    return bit_rep + 1;
  endfunction

  // round(2^(exp_bits-1) * e^(-k / 2^in_frac))
  function automatic int lut_entry(int k, int exp_bits, int in_frac);
    real v;
    v = (2.0 ** (exp_bits - 1)) * $exp(-real'(k) / (2.0 ** in_frac));
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/softmax_divider.sv
// Serial restoring divider, one quotient bit per cycle.
// Requires dividend >> QW < divisor so the quotient fits in QW bits.
module softmax_divider #(
  parameter int DW = 24,
  parameter int VW = 18,
  parameter int QW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(QW + 1);

  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [QW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [VW:0]   part;
  logic [VW:0]   diff;

  assign part     = {rem, sh[QW-1]};
  assign diff     = part - {1'b0, dvs};
  assign done     = (cnt == CW'(1));
  assign quotient = sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      dvs <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= VW'(dividend >> QW);
      sh  <= dividend[QW-1:0];
      dvs <= divisor;
      cnt <= CW'(QW);
    end else if (cnt != '0) begin
      // quotient bits shift in where dividend bits shift out
      if (!diff[VW]) begin
        rem <= diff[VW-1:0];
        sh  <= {sh[QW-2:0], 1'b1};
      end else begin
        rem <= part[VW-1:0];
        sh  <= {sh[QW-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/softmax_sequencer.sv
// Multi-pass softmax: buffer + max, exp LUT + sum, serial divide, stream out.
// One divider is shared by all elements of the vector.
module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int BIT_REP   = 8,
  parameter int IN_FRAC   = 4,
  parameter int IN_LENGTH = 10,
  parameter int EXP_BITS  = 16,
  parameter int OUT_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_REP-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int SUM_BITS = sum_bits(EXP_BITS, IN_LENGTH);
  localparam int D_BITS   = d_bits(BIT_REP);
  localparam int IW       = $clog2(IN_LENGTH);
  localparam int DW       = EXP_BITS + OUT_BITS;
  localparam int QW       = OUT_BITS + 1;
  localparam logic [IW-1:0] LAST = IW'(IN_LENGTH - 1);

  logic [1:0]                 state;
  logic [IW-1:0]              idx;
  logic signed [BIT_REP-1:0]  max_q;
  logic [SUM_BITS-1:0]        sum;
  logic [BIT_REP-1:0]         x_buf [IN_LENGTH];
  logic [EXP_BITS-1:0]        e_buf [IN_LENGTH];
  logic [EXP_BITS-1:0]        lut   [2**BIT_REP];

  for (genvar k = 0; k < 2**BIT_REP; k++) begin : g_lut
    assign lut[k] = EXP_BITS'(lut_entry(k, EXP_BITS, IN_FRAC));
  end

  logic [BIT_REP-1:0]  xb;
  logic [D_BITS-1:0]   d;
  logic [BIT_REP-1:0]  lut_idx;
  logic [EXP_BITS-1:0] e_val;
  logic [SUM_BITS-1:0] sum_nxt;
  logic                last;
  logic                accept;
  logic                out_fire;
  logic                div_start;
  logic                div_done;
  logic [IW-1:0]       div_idx;
  logic [DW-1:0]       dividend;
  logic [SUM_BITS-1:0] divisor;
  logic [QW-1:0]       q;

  assign xb      = x_buf[idx];
  assign d       = {max_q[BIT_REP-1], max_q} - {xb[BIT_REP-1], xb};
  assign lut_idx = d[BIT_REP] ? '1 : d[BIT_REP-1:0];
  assign e_val   = lut[lut_idx];
  assign sum_nxt = sum + SUM_BITS'(e_val);
  assign last    = (idx == LAST);

  assign in_ready  = (state == S_LOAD);
  assign accept    = in_valid && in_ready;
  assign out_fire  = (state == S_OUT) && out_ready;
  // divider loads on entry to DIV so DIV lasts exactly QW cycles
  assign div_start = ((state == S_EXP) && last) || (out_fire && !last);
  assign div_idx   = (state == S_EXP || last) ? '0 : idx + IW'(1);
  assign dividend  = {e_buf[div_idx], OUT_BITS'(0)};
  assign divisor   = (state == S_EXP) ? sum_nxt : sum;

  assign out_valid = (state == S_OUT);
  assign out_last  = out_valid && last;
  assign out_data  = !out_valid ? '0 :
                     q[OUT_BITS] ? '1 : q[OUT_BITS-1:0];
  assign busy      = !((state == S_LOAD) && (idx == '0));

  softmax_divider #(
    .DW(DW),
    .VW(SUM_BITS),
    .QW(QW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      idx   <= '0;
      max_q <= '0;
      sum   <= '0;
      for (int i = 0; i < IN_LENGTH; i++) begin
        x_buf[i] <= '0;
        e_buf[i] <= '0;
      end
    end else begin
      unique case (state)
        S_LOAD: begin
          if (accept) begin
            x_buf[idx] <= in_data;
            if (idx == '0 || $signed(in_data) > max_q)
              max_q <= $signed(in_data);
            if (last) begin
              state <= S_EXP;
              idx   <= '0;
              sum   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_EXP: begin
          e_buf[idx] <= e_val;
          sum        <= sum_nxt;
          if (last) begin
            state <= S_DIV;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DIV: begin
          if (div_done)
            state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (last) begin
              state <= S_LOAD;
              idx   <= '0;
            end else begin
              state <= S_DIV;
              idx   <= idx + IW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/softmax_sequencer.md
# softmax_sequencer

Multi-pass controller that runs a numerically stable softmax over one vector of IN_LENGTH signed activations from the final dense layer. It buffers the vector while tracking its maximum, then drives a shared exponent LUT once per element on max-x and accumulates the sum. It then time-multiplexes one serial divider to emit the normalised probabilities as a ready/valid stream.

## Interface
- BIT_REP, 8: width of signed input activations.
- IN_FRAC, 4: fractional bits of the input; LUT step is 2^-IN_FRAC.
- IN_LENGTH, 10: elements per vector, ≥2.
- EXP_BITS, 16: unsigned exp width; value Q1.(EXP_BITS-1), so exp(0)=2^(EXP_BITS-1).
- OUT_BITS, 8: unsigned probability width, Q0.OUT_BITS.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts an element (high only in LOAD).
- in_data  in  BIT_REP  signed activation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_BITS  probability of current element.
- out_last  out  1  marks element IN_LENGTH-1.
- busy  out  1  high in any state except LOAD with idx==0.

## Operation
- States: LOAD, EXP, DIV, OUT. Reset state is LOAD with idx=0, max=0, sum=0. out_valid=0, out_data=0, out_last=0. in_ready=1 once rst_n is high.
- LOAD: each in_valid&&in_ready writes x_buf[idx] and increments idx. The first element sets max; later elements set max to signed max(max, in_data). Accepting element IN_LENGTH-1 moves to EXP with idx=0 and sum=0.
- EXP: d = max - x_buf[idx], unsigned BIT_REP+1 bits. Index the LUT with d saturated to 2^BIT_REP-1. e_buf[idx] = lut(d). sum += lut(d); sum width is EXP_BITS+clog2(IN_LENGTH) with no overflow possible. One element per cycle. After the last element go to DIV with idx=0.
- LUT entry k = round(2^(EXP_BITS-1) * e^(-k/2^IN_FRAC)). Entries are computed at elaboration and are 0 where the value rounds to 0.
- DIV: restoring division q = floor(e_buf[idx] * 2^OUT_BITS / sum), OUT_BITS+1 quotient bits, one bit per cycle. out_data = min(q, 2^OUT_BITS-1). When the divider is done, go to OUT.
- OUT: out_valid=1 and out_last=(idx==IN_LENGTH-1).
  - On out_ready: if last, return to LOAD with idx=0. Otherwise increment idx and go to DIV.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable.
- sum is never 0, because the max element contributes 2^(EXP_BITS-1).
- Equal inputs, including ties at the max, are legal. Negative-only vectors are legal.
- Reset asserted in any state clears all state immediately and discards the partial vector. in_valid is ignored outside LOAD.

## Timing
- LOAD takes ≥IN_LENGTH cycles (one element per handshake cycle).
- LUT read and accumulate are combinational into registers, so EXP takes exactly IN_LENGTH cycles.
- DIV takes OUT_BITS+1 cycles per element; out_valid rises the cycle after the last quotient bit.
- Per element, with out_ready held high: OUT_BITS+2 cycles (DIV plus the one OUT cycle).
- Fill-to-first-output latency is IN_LENGTH+OUT_BITS+2 cycles after the last input handshake.
- in_ready rises the cycle after the out_last handshake.

## Structure
- Shared package softmax_pkg holds:
  - the state enum;
  - derived widths (SUM_BITS, D_BITS);
  - a function that generates the LUT entries.
- Sub-module softmax_divider, a serial restoring divider with start/done and parameterised dividend/divisor widths. It is instantiated once and shared across elements.
- The exponent LUT stays inline as a constant array.

## Test plan
- IN_LENGTH=4, IN_FRAC=0, inputs {5,5,5,5} -> exp each 32768, sum 131072, outputs {64,64,64,64}, out_last only on the 4th.
- IN_FRAC=0, inputs {0,-128,-128,-128} -> exp {32768,0,0,0}, q=256 saturates: outputs {255,0,0,0}.
- IN_FRAC=0, inputs {1,0,0,0} -> LUT(1)=12055, sum 68933, outputs {121,44,44,44}.
- Same vector with out_ready toggling 1/0 every cycle -> identical output values, out_data stable while stalled, no loss or duplicate.
- rst_n pulsed low mid-DIV on element 2 -> outputs zero immediately. The next full vector {5,5,5,5} yields {64,64,64,64} with no residue.
- Back-to-back vectors with in_valid held high -> in_ready low from EXP until after out_last. The second vector is accepted intact, and its max does not leak from the first.
